rom_rr_arbiter: RTL



---
 rtl/rom_rr_arbiter_if.sv | 25 ++
 rtl/rom_rr_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/rom_rr_arbiter_if.sv
// rom_rr_arbiter_if: request and response channels between client blocks and the ROM arbiter
interface rom_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: round-robin sharing of one synchronous-read ROM port, one transaction in flight
module rom_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int RD_LAT  = 1,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_rr_arbiter_if.slave   bus,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data
);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, id, gnt;
    logic               any_req;
    logic [CNT_W-1:0]   cnt;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [DATA_W-1:0]  rsp_data_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

    // Pick the first valid requester at or above ptr, wrapping; later passes override earlier ones
    always_comb begin
        gnt     = ptr;
        any_req = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_valid[i] && i < int'(ptr)) begin
                gnt     = ID_W'(i);
                any_req = 1'b1;
            end
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_valid[i] && i >= int'(ptr)) begin
                gnt     = ID_W'(i);
                any_req = 1'b1;
            end
    end

    // State register
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nxt;

    // Next state and the combinational accept, which only fires in IDLE outside reset
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                state_nxt     = any_req ? ISSUE : IDLE;
                bus.req_ready = (rst_n && any_req) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt) : '0;
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (cnt == CNT_W'(1)) ? RESP : WAIT;
            RESP:    state_nxt = bus.rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction datapath: latch grant, pulse the ROM enable, count latency, hold the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rom_en <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    id       <= gnt;
                    rom_addr <= bus.req_addr[gnt*ADDR_W +: ADDR_W];
                    rom_en   <= 1'b1;
                    ptr      <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
                end
                ISSUE: cnt <= CNT_W'(RD_LAT);
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_data_q  <= rom_data;
                        rsp_id_q    <= id;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
